tenkey_scanner: RTL and testbench
=================================

TENKEY_SCANNER -- requirements
Module: tenkey_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clocks each row is driven per scan slot (minimum 3).
REQ-002 Parameter DEBOUNCE, default 8: consecutive stable clocks required to accept a press or a release (minimum 2).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row  output  4  keypad row drive, active-high, at most one bit set.
REQ-006 col  input  3  keypad column sense, active-high, asynchronous to clk.
REQ-007 tenkey  output  10  one-hot digit strobe, bit n = digit n, one clk wide.
REQ-008 close  output  1  one-clk strobe on '*' key.

Function
REQ-009 Key map (row,col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#.
REQ-010 col passes through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-011 FSM states: SCAN, DEBOUNCE, EMIT, RELEASE.
REQ-012 SCAN: row = one-hot of row index; the index advances 0->1->2->3->0 every SCAN_DIV clocks.
REQ-013 SCAN: col_s is sampled on the last clock of each row slot; any bit set -> latch row index and lowest set column index -> DEBOUNCE, with row held.
REQ-014 DEBOUNCE: counter increments each clock while the latched col_s bit = 1.
REQ-015 DEBOUNCE: if the latched bit drops -> SCAN at the next row index, counter cleared.
REQ-016 DEBOUNCE: counter reaching DEBOUNCE -> EMIT.
REQ-017 EMIT lasts exactly one clk: tenkey = one-hot digit for digits; close = 1 for '*'; '#' produces no strobe; then -> RELEASE.
REQ-018 RELEASE: row held; counter counts consecutive clocks with latched col_s bit = 0 and resets to 0 when the bit returns to 1.
REQ-019 RELEASE: counter reaching DEBOUNCE -> SCAN at the next row index.
REQ-020 Outside EMIT, tenkey = 10'b0 and close = 0; tenkey and close are never both nonzero.
REQ-021 Other keys pressed while in DEBOUNCE or RELEASE are ignored; there is no rollover queue.
REQ-022 Multiple columns set at the SCAN sample -> lowest column index wins.
REQ-023 Latency: press stable from the slot sample -> strobe exactly DEBOUNCE+1 clocks after the sample clock.
REQ-024 Counter width = clog2(max(SCAN_DIV,DEBOUNCE)+1); no wrap is possible.

Reset
REQ-025 reset asserted (any time, including mid-DEBOUNCE or mid-EMIT) immediately forces state = SCAN, row index 0, row = 4'b0001, counters 0, synchronizer flops 0, tenkey = 0, close = 0.
REQ-026 After reset release, the first row slot is row 0 with a full SCAN_DIV clocks.

Structure
REQ-027 Package elelock_pkg holds the FSM state enum, the row/col key map table, and digit codes 4'h0..4'h9 shared with the lock's key encoder.
REQ-028 One combinational sub-module, tenkey_map, maps (row index, col index) to {tenkey one-hot, close, is_hash}.
REQ-029 Outputs tenkey and close are registered.

Verification
REQ-030 Press '3' (r0,c2) held 40 clks -> exactly one tenkey = 10'b0000001000 pulse; row stays 4'b0001 until release plus DEBOUNCE clks.
REQ-031 Press '0' (r3,c1) for 5 clks only -> no strobe; scanning resumes at row 0.
REQ-032 Press '*' -> close = 1 for one clk, tenkey = 0; press '#' -> neither strobes.
REQ-033 Bounce: col toggles every 2 clks for 20 clks, then stable -> exactly one strobe after DEBOUNCE stable clks; release bounce -> no second strobe.
REQ-034 Hold '7' and '9' together (r2,c0+c2) -> only tenkey bit 7 strobes.
REQ-035 Assert reset during DEBOUNCE of '5' -> outputs 0, row = 4'b0001 asynchronously; no strobe after release unless the key is re-held for the full debounce.

Source files
------------

// File: rtl/elelock_pkg.sv
// Shared definitions for the lock keypad front end:
// scanner FSM states, keypad layout and key codes.
package elelock_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } scan_state_t;

    typedef logic [3:0] key_code_t;

    localparam key_code_t DIGIT_0 = 4'h0;
    localparam key_code_t DIGIT_1 = 4'h1;
    localparam key_code_t DIGIT_2 = 4'h2;
    localparam key_code_t DIGIT_3 = 4'h3;
    localparam key_code_t DIGIT_4 = 4'h4;
    localparam key_code_t DIGIT_5 = 4'h5;
    localparam key_code_t DIGIT_6 = 4'h6;
    localparam key_code_t DIGIT_7 = 4'h7;
    localparam key_code_t DIGIT_8 = 4'h8;
    localparam key_code_t DIGIT_9 = 4'h9;
    localparam key_code_t KEY_STAR = 4'hA;
    localparam key_code_t KEY_HASH = 4'hB;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 3;

    // Physical keypad layout, indexed [row][col].
    localparam key_code_t KEY_MAP [KP_ROWS][KP_COLS] = '{
        '{DIGIT_1, DIGIT_2, DIGIT_3},
        '{DIGIT_4, DIGIT_5, DIGIT_6},
        '{DIGIT_7, DIGIT_8, DIGIT_9},
        '{KEY_STAR, DIGIT_0, KEY_HASH}
    };

    // Lowest active column wins when several keys share a row.
    function automatic logic [1:0] lowest_col(input logic [2:0] c);
        logic [1:0] idx;
        idx = 2'd2;
        if (c[1]) idx = 2'd1;
        if (c[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/tenkey_map.sv
// Maps a latched keypad position to the strobe pattern:
// one-hot digit, close for '*', is_hash for '#'.
module tenkey_map
    import elelock_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [9:0] tenkey,
    output logic       close,
    output logic       is_hash
);

    key_code_t code;

    // Decode the key code into exactly one of the three outputs.
    always_comb begin
        code    = KEY_MAP[row_idx][col_idx];
        tenkey  = '0;
        close   = 1'b0;
        is_hash = 1'b0;
        if (code == KEY_STAR) begin
            close = 1'b1;
        end else if (code == KEY_HASH) begin
            is_hash = 1'b1;
        end else if (code <= DIGIT_9) begin
            tenkey = 10'(1) << code;
        end
    end

endmodule

// File: rtl/tenkey_scanner.sv
// 4x3 keypad scanner: row scan, debounce of press and release,
// one-clock registered digit / close strobes.
module tenkey_scanner
    import elelock_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row,
    input  logic [2:0] col,
    output logic [9:0] tenkey,
    output logic       close
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_DONE = CW'(DEBOUNCE);

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] col_s;

    scan_state_t state_q, state_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0] tenkey_q, tenkey_d;
    logic close_q, close_d;

    logic key_bit;
    logic [9:0] map_tenkey;
    logic map_close;
    logic map_hash;

    assign col_s = sync2_q;
    assign key_bit = col_s[col_idx_q];

    tenkey_map u_map (
        .row_idx (row_idx_q),
        .col_idx (col_idx_q),
        .tenkey  (map_tenkey),
        .close   (map_close),
        .is_hash (map_hash)
    );

    // Two-flop synchronizer for the asynchronous column sense lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= col;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: scan slots, press/release debounce, strobe.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        tenkey_d  = '0;
        close_d   = 1'b0;
        unique case (state_q)
            ST_SCAN: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (|col_s) begin
                        col_idx_d = lowest_col(col_s);
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!key_bit) begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    cnt_d     = '0;
                end else if (cnt_q == DEB_DONE) begin
                    state_d  = ST_EMIT;
                    cnt_d    = '0;
                    tenkey_d = map_hash ? '0 : map_tenkey;
                    close_d  = map_close;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EMIT: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
            ST_RELEASE: begin
                if (key_bit) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_DONE) begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    // Scanner FSM state, counters and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SCAN;
            row_idx_q <= '0;
            col_idx_q <= '0;
            cnt_q     <= '0;
            tenkey_q  <= '0;
            close_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            tenkey_q  <= tenkey_d;
            close_q   <= close_d;
        end
    end

    assign row    = 4'b0001 << row_idx_q;
    assign tenkey = tenkey_q;
    assign close  = close_q;

endmodule

// File: tb/tb_tenkey_scanner.sv
// Directed bench for tenkey_scanner with a keypad model
// and a strobe scoreboard.
module tb_tenkey_scanner;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam logic [10:0] STAR = 11'b0000000000_1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [2:0] col;
    logic [9:0] tenkey;
    logic       close;

    logic [2:0] keys [4];
    logic [10:0] exp_q [$];
    logic [10:0] mon_exp;
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    tenkey_scanner #(
        .SCAN_DIV (SD),
        .DEBOUNCE (DB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .row    (row),
        .col    (col),
        .tenkey (tenkey),
        .close  (close)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key connects its row drive to its column.
    assign col = ({3{row[0]}} & keys[0]) | ({3{row[1]}} & keys[1])
               | ({3{row[2]}} & keys[2]) | ({3{row[3]}} & keys[3]);

    function automatic logic [10:0] dig(input int d);
        logic [9:0] t;
        t = 10'(1) << d;
        return {t, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: invariants every cycle, scoreboard on strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            assert (!((|tenkey) && close)) else begin
                bad++;
                $error("FAIL both_strobes got=%0h/%0b want=exclusive",
                       tenkey, close);
            end
            total++;
            assert ($onehot0(row)) else begin
                bad++;
                $error("FAIL row_onehot got=%0b want=onehot0", row);
            end
            if ((|tenkey) || close) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_strobe got=%0h/%0b want=none",
                           tenkey, close);
                end
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    total++;
                    assert ({tenkey, close} === mon_exp) else begin
                        bad++;
                        $error("FAIL strobe got=%0h want=%0h",
                               {tenkey, close}, mon_exp);
                    end
                end
            end
        end
    end

    task automatic wait_row_start(input int r);
        int n;
        n = 0;
        while (row[r] && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (!row[r] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("row_start", 32'(row[r]), 32'd1);
    endtask

    task automatic press(input int r, input logic [2:0] c, input int hold,
                         input bit want, input logic [10:0] e);
        wait_row_start(r);
        if (want) exp_q.push_back(e);
        keys[r] = c;
        repeat (hold) @(negedge clk);
        keys[r] = 3'b000;
        repeat (DB + 16) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        bit ok;
        for (int i = 0; i < 4; i++) keys[i] = 3'b000;

        // Reset state and first full row-0 slot.
        repeat (3) @(negedge clk);
        chk("rst_row", 32'(row), 32'h1);
        chk("rst_tenkey", 32'(tenkey), 32'h0);
        chk("rst_close", 32'(close), 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (row !== 4'b0001) ok = 1'b0;
        end
        chk("slot0_len", 32'(ok), 32'd1);
        @(negedge clk);
        chk("slot1_row", 32'(row), 32'h2);

        // Latency: '1' held through reset release.
        reset = 1'b1;
        @(negedge clk);
        keys[0] = 3'b001;
        exp_q.push_back(dig(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((|tenkey) && lat == 0) lat = k;
        end
        chk("latency", 32'(lat), 32'(SD + DB + 1));
        keys[0] = 3'b000;
        repeat (DB + 16) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        // '3' held 40 clocks, row held until release debounced.
        wait_row_start(0);
        exp_q.push_back(dig(3));
        keys[0] = 3'b100;
        repeat (40) @(negedge clk);
        chk("hold3_row", 32'(row), 32'h1);
        keys[0] = 3'b000;
        ok = 1'b1;
        repeat (DB) begin
            @(negedge clk);
            if (row !== 4'b0001) ok = 1'b0;
        end
        chk("rel3_row_held", 32'(ok), 32'd1);
        n = 0;
        while (row === 4'b0001 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rel3_next_row", 32'(row), 32'h2);
        repeat (10) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        // '0' for 5 clocks only: aborted, scan resumes at row 0.
        wait_row_start(3);
        keys[3] = 3'b010;
        repeat (5) @(negedge clk);
        keys[3] = 3'b000;
        n = 0;
        while (row === 4'b1000 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("short0_row", 32'(row), 32'h1);
        repeat (DB + 16) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        // '*' gives close only; '#' gives nothing.
        press(3, 3'b001, 20, 1'b1, STAR);
        press(3, 3'b100, 20, 1'b0, 11'd0);

        // Bounce on press and release of '5'.
        wait_row_start(1);
        exp_q.push_back(dig(5));
        for (int i = 0; i < 10; i++) begin
            keys[1] = (i % 2 == 0) ? 3'b010 : 3'b000;
            repeat (2) @(negedge clk);
        end
        keys[1] = 3'b010;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            keys[1] = (i % 2 == 0) ? 3'b000 : 3'b010;
            repeat (2) @(negedge clk);
        end
        keys[1] = 3'b000;
        repeat (DB + 16) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        // '7' and '9' together: lowest column wins.
        press(2, 3'b101, 30, 1'b1, dig(7));

        // Reset in the middle of debouncing '5'.
        wait_row_start(1);
        keys[1] = 3'b010;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_row", 32'(row), 32'h1);
        chk("mid_rst_tenkey", 32'(tenkey), 32'h0);
        chk("mid_rst_close", 32'(close), 32'h0);
        keys[1] = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        press(1, 3'b010, 30, 1'b1, dig(5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
